// File: rtl/reflet_float_dispatch.sv
// Issue stage for reflet_float_au: owns a small float register file, issues one
// AU operation at a time, writes the float result back and reports int/compare results.
module reflet_float_dispatch #(
  parameter int float_size    = 32,
  parameter int integer_size  = 16,
  parameter int reg_addr_size = 3,
  parameter int timeout       = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [5:0]               req_opcode,
  input  logic [1:0]               req_ctrl_flag,
  input  logic [reg_addr_size-1:0] req_src1,
  input  logic [reg_addr_size-1:0] req_src2,
  input  logic [reg_addr_size-1:0] req_src3,
  input  logic [reg_addr_size-1:0] req_dst,
  input  logic                     req_wr_flt,
  input  logic [integer_size-1:0]  req_int_in,
  input  logic                     ld_en,
  input  logic [reg_addr_size-1:0] ld_addr,
  input  logic [float_size-1:0]    ld_data,
  input  logic [reg_addr_size-1:0] rd_addr,
  output logic [float_size-1:0]    rd_data,
  output logic                     au_enable,
  output logic [5:0]               au_opcode,
  output logic [1:0]               au_ctrl_flag,
  output logic [float_size-1:0]    au_flt_in1,
  output logic [float_size-1:0]    au_flt_in2,
  output logic [float_size-1:0]    au_flt_in3,
  output logic [integer_size-1:0]  au_int_in,
  input  logic                     au_ready,
  input  logic                     au_cmp_flag,
  input  logic [float_size-1:0]    au_flt_out,
  input  logic [integer_size-1:0]  au_int_out,
  output logic                     rsp_valid,
  output logic                     rsp_error,
  output logic [integer_size-1:0]  rsp_int,
  output logic                     rsp_cmp,
  output logic                     busy
);

  localparam int num_regs = 2 ** reg_addr_size;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t                   state_q, state_d;
  logic [float_size-1:0]    regs_q [num_regs];
  logic [float_size-1:0]    regs_d [num_regs];
  logic [float_size-1:0]    rd_data_q, rd_data_d;
  logic [5:0]               opcode_q, opcode_d;
  logic [1:0]               ctrl_q, ctrl_d;
  logic [integer_size-1:0]  int_in_q, int_in_d;
  logic [reg_addr_size-1:0] dst_q, dst_d;
  logic                     wr_flt_q, wr_flt_d;
  logic [float_size-1:0]    in1_q, in1_d;
  logic [float_size-1:0]    in2_q, in2_d;
  logic [float_size-1:0]    in3_q, in3_d;
  logic [float_size-1:0]    flt_res_q, flt_res_d;
  logic [integer_size-1:0]  rsp_int_q, rsp_int_d;
  logic                     rsp_cmp_q, rsp_cmp_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_error_q, rsp_error_d;
  logic                     au_enable_q, au_enable_d;
  logic [7:0]               wdog_q, wdog_d;
  logic [8:0]               wdog_inc;

  assign req_ready = (state_q == IDLE) && !ld_en;

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    rd_data_d   = regs_q[rd_addr];
    opcode_d    = opcode_q;
    ctrl_d      = ctrl_q;
    int_in_d    = int_in_q;
    dst_d       = dst_q;
    wr_flt_d    = wr_flt_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    in3_d       = in3_q;
    flt_res_d   = flt_res_q;
    rsp_int_d   = rsp_int_q;
    rsp_cmp_d   = rsp_cmp_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    au_enable_d = 1'b0;
    wdog_d      = wdog_q;
    wdog_inc    = {1'b0, wdog_q} + 9'd1;

    case (state_q)
      IDLE: begin
        // A host load takes the cycle; the request waits for the next one.
        if (ld_en) begin
          regs_d[ld_addr] = ld_data;
        end else if (req_valid) begin
          opcode_d    = req_opcode;
          ctrl_d      = req_ctrl_flag;
          int_in_d    = req_int_in;
          dst_d       = req_dst;
          wr_flt_d    = req_wr_flt;
          in1_d       = regs_q[req_src1];
          in2_d       = regs_q[req_src2];
          in3_d       = regs_q[req_src3];
          au_enable_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d      = 8'd0;
        au_enable_d = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (au_ready) begin
          flt_res_d   = au_flt_out;
          rsp_int_d   = au_int_out;
          rsp_cmp_d   = au_cmp_flag;
          rsp_valid_d = 1'b1;
          state_d     = WB;
        end else if (wdog_inc >= 9'(timeout)) begin
          rsp_error_d = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = WB;
        end else begin
          wdog_d      = wdog_inc[7:0];
          au_enable_d = 1'b1;
        end
      end
      WB: begin
        // rsp_error_q is high exactly during an aborted WB, so it gates the write.
        if (!rsp_error_q && wr_flt_q) begin
          regs_d[dst_q] = flt_res_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < num_regs; i++) regs_q[i] <= '0;
      rd_data_q   <= '0;
      opcode_q    <= '0;
      ctrl_q      <= '0;
      int_in_q    <= '0;
      dst_q       <= '0;
      wr_flt_q    <= 1'b0;
      in1_q       <= '0;
      in2_q       <= '0;
      in3_q       <= '0;
      flt_res_q   <= '0;
      rsp_int_q   <= '0;
      rsp_cmp_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      au_enable_q <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      rd_data_q   <= rd_data_d;
      opcode_q    <= opcode_d;
      ctrl_q      <= ctrl_d;
      int_in_q    <= int_in_d;
      dst_q       <= dst_d;
      wr_flt_q    <= wr_flt_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      in3_q       <= in3_d;
      flt_res_q   <= flt_res_d;
      rsp_int_q   <= rsp_int_d;
      rsp_cmp_q   <= rsp_cmp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      au_enable_q <= au_enable_d;
      wdog_q      <= wdog_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign rd_data      = rd_data_q;
  assign au_enable    = au_enable_q;
  assign au_opcode    = opcode_q;
  assign au_ctrl_flag = ctrl_q;
  assign au_flt_in1   = in1_q;
  assign au_flt_in2   = in2_q;
  assign au_flt_in3   = in3_q;
  assign au_int_in    = int_in_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_error    = rsp_error_q;
  assign rsp_int      = rsp_int_q;
  assign rsp_cmp      = rsp_cmp_q;

endmodule
